// File: rtl/bk_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bk_mem_pkg
//  Purpose  : Shared types and constants for the memory-block copy initiator.
//  Revision : 1.0  initial release
// ============================================================================
package bk_mem_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LD_LO = 4'd1,
        ST_LD_HI = 4'd2,
        ST_WR    = 4'd3,
        ST_GAP   = 4'd4,
        ST_RD    = 4'd5,
        ST_TX_LO = 4'd6,
        ST_TX_HI = 4'd7,
        ST_DONE  = 4'd8
    } mcm_state_t;

    typedef enum logic [1:0] {
        TP_IDLE = 2'd0,
        TP_HIGH = 2'd1,
        TP_LOW  = 2'd2
    } tmr_phase_t;

    localparam int TMR_W = 8;

    // ROM image placement used by the loader when generating start addresses
    localparam logic [24:0] ROM_P10         = 25'h0100000;
    localparam logic [24:0] A16M_ROM        = 25'h0120000;
    localparam logic [24:0] SMK512_ROM      = 25'h0140000;
    localparam logic [24:0] BIOS11          = 25'h0160000;
    localparam logic [24:0] START_ADDR_OFFS = 25'hFCE;

endpackage
`default_nettype wire

// File: rtl/mem_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pulse_timer
//  Purpose  : One-shot pulse generator (high N, low M) shared by we and rd.
//  Revision : 1.0  initial release
// ============================================================================
module mem_pulse_timer
    import bk_mem_pkg::*;
#(
    parameter int CNT_W = TMR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_sel_rd,
    input  logic [CNT_W-1:0] i_hi_len,
    input  logic [CNT_W-1:0] i_lo_len,
    input  logic             i_abort,
    output logic             o_we,
    output logic             o_rd,
    output logic             o_last_hi,
    output logic             o_finish,
    output logic             o_idle
);

    tmr_phase_t       r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic             r_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= TP_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_rd    <= 1'b0;
        end else if (i_abort) begin
            r_phase <= TP_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            case (r_phase)
                TP_IDLE: begin
                    if (i_start) begin
                        r_phase <= TP_HIGH;
                        r_cnt   <= i_hi_len - CNT_W'(1);
                        r_we    <= !i_sel_rd;
                        r_rd    <= i_sel_rd;
                    end
                end
                TP_HIGH: begin
                    if (r_cnt == '0) begin
                        r_phase <= TP_LOW;
                        r_cnt   <= i_lo_len - CNT_W'(1);
                        r_we    <= 1'b0;
                        r_rd    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                TP_LOW: begin
                    if (r_cnt == '0) begin
                        r_phase <= TP_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_phase <= TP_IDLE;
            endcase
        end
    end

    assign o_we      = r_we;
    assign o_rd      = r_rd;
    assign o_last_hi = (r_phase == TP_HIGH) && (r_cnt == '0);
    assign o_finish  = (r_phase == TP_LOW) && (r_cnt == '0);
    assign o_idle    = (r_phase == TP_IDLE);

endmodule
`default_nettype wire

// File: rtl/mem_copy_master.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_master
//  Purpose  : Byte-stream <-> 16-bit SDRAM word copier driving mem_copy port.
//  Revision : 1.0  initial release
// ============================================================================
module mem_copy_master
    import bk_mem_pkg::*;
#(
    parameter int WE_CYCLES  = 4,
    parameter int RD_CYCLES  = 6,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk_bus,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic        cmd_save,
    input  logic        cmd_virt,
    input  logic [24:0] cmd_base,
    input  logic [16:0] cmd_len,
    input  logic        cmd_abort,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        mem_copy,
    output logic        mem_copy_virt,
    output logic [24:0] mem_copy_addr,
    output logic [15:0] mem_copy_data_i,
    input  logic [15:0] mem_copy_data_o,
    output logic        mem_copy_we,
    output logic        mem_copy_rd
);

    localparam logic [TMR_W-1:0] c_we_len  = TMR_W'(WE_CYCLES);
    localparam logic [TMR_W-1:0] c_rd_len  = TMR_W'(RD_CYCLES);
    localparam logic [TMR_W-1:0] c_gap_len = TMR_W'(GAP_CYCLES);

    mcm_state_t  r_state;
    logic [24:0] r_addr;
    logic [16:0] r_len;
    logic [16:0] r_count;
    logic        r_save;
    logic        r_virt;
    logic        r_busy;
    logic        r_mem_copy;
    logic        r_done;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic [15:0] r_wdata;
    logic [7:0]  r_rdata_hi;
    logic        r_tmr_start;
    logic        r_tmr_rd;

    logic        w_abort;
    logic        w_tmr_last_hi;
    logic        w_tmr_finish;
    logic        w_tmr_idle;
    logic [16:0] w_next_count;
    logic        w_hi_in_len;

    assign w_abort      = cmd_abort && (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_hi_in_len  = (r_count + 17'd1) < r_len;
    assign w_next_count = ((r_count + 17'd2) > r_len) ? r_len : (r_count + 17'd2);

    mem_pulse_timer #(
        .CNT_W (TMR_W)
    ) u_pulse_timer (
        .clk       (clk_bus),
        .rst_n     (reset_n),
        .i_start   (r_tmr_start),
        .i_sel_rd  (r_tmr_rd),
        .i_hi_len  (r_tmr_rd ? c_rd_len : c_we_len),
        .i_lo_len  (c_gap_len),
        .i_abort   (w_abort),
        .o_we      (mem_copy_we),
        .o_rd      (mem_copy_rd),
        .o_last_hi (w_tmr_last_hi),
        .o_finish  (w_tmr_finish),
        .o_idle    (w_tmr_idle)
    );

    always_ff @(posedge clk_bus or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_save      <= 1'b0;
            r_virt      <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_copy  <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_wdata     <= '0;
            r_rdata_hi  <= '0;
            r_tmr_start <= 1'b0;
            r_tmr_rd    <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_tmr_start <= 1'b0;
            if (w_abort) begin
                // A byte accepted this cycle is dropped together with any half word
                r_state     <= ST_DONE;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_start) begin
                            r_addr     <= cmd_base & ~25'd1;
                            r_len      <= cmd_len;
                            r_count    <= '0;
                            r_save     <= cmd_save;
                            r_virt     <= cmd_virt;
                            r_busy     <= 1'b1;
                            r_mem_copy <= 1'b1;
                            if (cmd_len == '0) begin
                                r_state <= ST_DONE;
                            end else if (cmd_save) begin
                                r_state     <= ST_RD;
                                r_tmr_start <= 1'b1;
                                r_tmr_rd    <= 1'b1;
                            end else begin
                                r_state    <= ST_LD_LO;
                                r_in_ready <= 1'b1;
                            end
                        end
                    end
                    ST_LD_LO: begin
                        if (in_valid && r_in_ready) begin
                            r_wdata[7:0] <= in_data;
                            if (w_hi_in_len) begin
                                r_state <= ST_LD_HI;
                            end else begin
                                r_wdata[15:8] <= 8'h00;
                                r_in_ready    <= 1'b0;
                                r_state       <= ST_WR;
                                r_tmr_start   <= 1'b1;
                                r_tmr_rd      <= 1'b0;
                            end
                        end
                    end
                    ST_LD_HI: begin
                        if (in_valid && r_in_ready) begin
                            r_wdata[15:8] <= in_data;
                            r_in_ready    <= 1'b0;
                            r_state       <= ST_WR;
                            r_tmr_start   <= 1'b1;
                            r_tmr_rd      <= 1'b0;
                        end
                    end
                    ST_WR: begin
                        if (w_tmr_last_hi) r_state <= ST_GAP;
                    end
                    ST_RD: begin
                        if (w_tmr_last_hi) begin
                            r_rdata_hi  <= mem_copy_data_o[15:8];
                            r_out_data  <= mem_copy_data_o[7:0];
                            r_out_valid <= 1'b1;
                            r_state     <= ST_TX_LO;
                        end
                    end
                    ST_TX_LO: begin
                        if (out_ready) begin
                            if (w_hi_in_len) begin
                                r_out_data <= r_rdata_hi;
                                r_state    <= ST_TX_HI;
                            end else begin
                                r_out_valid <= 1'b0;
                                r_state     <= ST_GAP;
                            end
                        end
                    end
                    ST_TX_HI: begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        // On the save path the low phase may already have elapsed during TX
                        if (w_tmr_finish || w_tmr_idle) begin
                            r_addr  <= r_addr + 25'd2;
                            r_count <= w_next_count;
                            if (w_next_count >= r_len) begin
                                r_state <= ST_DONE;
                            end else if (r_save) begin
                                r_state     <= ST_RD;
                                r_tmr_start <= 1'b1;
                                r_tmr_rd    <= 1'b1;
                            end else begin
                                r_state    <= ST_LD_LO;
                                r_in_ready <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_mem_copy <= 1'b0;
                        r_virt     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign in_ready        = r_in_ready;
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign mem_copy        = r_mem_copy;
    assign mem_copy_virt   = r_virt;
    assign mem_copy_addr   = r_addr;
    assign mem_copy_data_i = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_copy_master
//  Purpose  : Randomised scoreboard bench for the mem_copy initiator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_copy_master;

    localparam int WE_N = 4;
    localparam int RD_N = 6;

    logic        clk_bus = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0, cmd_save = 1'b0, cmd_virt = 1'b0, cmd_abort = 1'b0;
    logic [24:0] cmd_base = '0;
    logic [16:0] cmd_len = '0;
    logic        busy, done, in_ready, out_valid;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;
    logic        mem_copy, mem_copy_virt, mem_copy_we, mem_copy_rd;
    logic [24:0] mem_copy_addr;
    logic [15:0] mem_copy_data_i;
    logic [15:0] mem_copy_data_o;

    always #5 clk_bus = ~clk_bus;

    mem_copy_master #(.WE_CYCLES(WE_N), .RD_CYCLES(RD_N), .GAP_CYCLES(1)) dut (
        .clk_bus(clk_bus), .reset_n(reset_n),
        .cmd_start(cmd_start), .cmd_save(cmd_save), .cmd_virt(cmd_virt),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_copy(mem_copy), .mem_copy_virt(mem_copy_virt),
        .mem_copy_addr(mem_copy_addr), .mem_copy_data_i(mem_copy_data_i),
        .mem_copy_data_o(mem_copy_data_o),
        .mem_copy_we(mem_copy_we), .mem_copy_rd(mem_copy_rd)
    );

    typedef struct {
        logic [24:0] addr;
        logic [15:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_wr[$];
    logic [7:0]  exp_out[$];
    logic [7:0]  load_bytes[$];
    logic [15:0] mem_seed = 16'h0;
    logic        exp_virt = 1'b0;
    int          exp_dones = 0, done_seen = 0;
    int          we_rises = 0, rd_rises = 0;
    bit          ign_we_len = 0, ign_rd_len = 0;
    int          ready_mode = 0;

    // Simple memory image: each word is a hash of its word address
    function automatic logic [15:0] mem_word(input logic [24:0] a, input logic [15:0] seed);
        logic [15:0] p;
        p = a[16:1] * 16'h9E37;
        return p ^ seed;
    endfunction

    always @(mem_copy_addr or mem_seed) mem_copy_data_o = mem_word(mem_copy_addr, mem_seed);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk_bus); #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Write monitor: pops the expected word at every we rising edge
    initial begin
        logic        prev_we = 1'b0;
        int          hi_len = 0;
        logic [24:0] prev_addr = '0;
        logic [15:0] prev_wd = '0;
        wr_t         w;
        forever begin
            @(negedge clk_bus);
            if (mem_copy_we && !prev_we) begin
                we_rises++;
                hi_len = 1;
                check("we_setup_addr", mem_copy_addr, prev_addr);
                check("we_setup_data", mem_copy_data_i, prev_wd);
                check("we_virt", mem_copy_virt, exp_virt);
                n_checks++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h", mem_copy_addr, mem_copy_data_i);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", mem_copy_addr, w.addr);
                    check("wr_data", mem_copy_data_i, w.data);
                end
            end else if (mem_copy_we) begin
                hi_len++;
                check("we_hold_addr", mem_copy_addr, prev_addr);
                check("we_hold_data", mem_copy_data_i, prev_wd);
            end else if (prev_we && !ign_we_len) begin
                check("we_pulse_len", hi_len, WE_N);
            end
            prev_we   = mem_copy_we;
            prev_addr = mem_copy_addr;
            prev_wd   = mem_copy_data_i;
        end
    end

    initial begin
        logic prev_rd = 1'b0;
        int   hi_len = 0;
        forever begin
            @(negedge clk_bus);
            if (mem_copy_rd && !prev_rd) begin
                rd_rises++;
                hi_len = 1;
                check("rd_virt", mem_copy_virt, exp_virt);
            end else if (mem_copy_rd) begin
                hi_len++;
            end else if (prev_rd && !ign_rd_len) begin
                check("rd_pulse_len", hi_len, RD_N);
            end
            prev_rd = mem_copy_rd;
        end
    end

    // Output stream monitor with stall-hold checking
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] stall_data = '0;
        logic [7:0] b;
        forever begin
            @(negedge clk_bus);
            if (prev_stall) begin
                check("out_hold_valid", out_valid, 1'b1);
                check("out_hold_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_out.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_byte: got %0h", out_data);
                end else begin
                    b = exp_out.pop_front();
                    check("out_byte", out_data, b);
                end
            end
            prev_stall = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    initial begin
        logic prev_done = 1'b0;
        forever begin
            @(negedge clk_bus);
            if (done) begin
                done_seen++;
                check("done_single_cycle", prev_done, 1'b0);
                check("done_busy_low", busy, 1'b0);
                check("done_mem_copy_low", mem_copy, 1'b0);
                check("done_virt_low", mem_copy_virt, 1'b0);
                check("done_in_ready_low", in_ready, 1'b0);
                check("done_out_valid_low", out_valid, 1'b0);
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic save, input logic virt, input logic [24:0] base, input int len);
        cmd_save  = save;
        cmd_virt  = virt;
        cmd_base  = base;
        cmd_len   = 17'(len);
        cmd_start = 1'b1;
        @(posedge clk_bus); #1;
        cmd_start = 1'b0;
    endtask

    // Feeds n bytes; also throws ignored start strobes with junk fields at the busy DUT
    task automatic feed(input int n);
        int i = 0;
        int guard = 0;
        bit hs;
        while (i < n && guard < 2000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = load_bytes[i];
            cmd_start = ($urandom_range(0, 7) == 0);
            cmd_base  = 25'($urandom);
            cmd_len   = 17'($urandom_range(0, 20));
            @(negedge clk_bus);
            hs = in_valid && in_ready;
            @(posedge clk_bus); #1;
            if (hs) i++;
            guard++;
        end
        in_valid  = 1'b0;
        cmd_start = 1'b0;
        check("feed_within_budget", 32'(guard < 2000), 1);
    endtask

    task automatic wait_done(input bit chk_ready_low);
        int g = 0;
        bit seen = 0;
        while (!seen && g < 3000) begin
            @(negedge clk_bus);
            if (done) seen = 1;
            else if (chk_ready_low) check("in_ready_low_after_last", in_ready, 1'b0);
            g++;
        end
        check("done_within_budget", seen, 1'b1);
        @(posedge clk_bus); #1;
    endtask

    task automatic run_load(input logic [24:0] base, input int len, input logic virt, input bit chk_ready);
        int          w0 = we_rises;
        logic [24:0] a = base & ~25'd1;
        wr_t         w;
        for (int i = 0; i < len; i += 2) begin
            w.addr = a + 25'(i);
            w.data = {(i + 1 < len) ? load_bytes[i + 1] : 8'h00, load_bytes[i]};
            exp_wr.push_back(w);
        end
        exp_virt = virt;
        issue(1'b0, virt, base, len);
        feed(len);
        wait_done(chk_ready);
        exp_dones++;
        check("load_we_count", we_rises - w0, (len + 1) / 2);
        check("load_queue_drained", exp_wr.size(), 0);
    endtask

    task automatic run_save(input logic [24:0] base, input int len, input logic virt, input int mode);
        int          r0 = rd_rises;
        logic [24:0] a = base & ~25'd1;
        logic [15:0] wd;
        for (int i = 0; i < len; i++) begin
            wd = mem_word(a + 25'(i & ~1), mem_seed);
            exp_out.push_back((i % 2 == 1) ? wd[15:8] : wd[7:0]);
        end
        ready_mode = mode;
        exp_virt   = virt;
        issue(1'b1, virt, base, len);
        wait_done(1'b0);
        exp_dones++;
        ready_mode = 0;
        check("save_rd_count", rd_rises - r0, (len + 1) / 2);
        check("save_queue_drained", exp_out.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, r0, g, len;
        logic [24:0] base;
        logic virt;
        wr_t w;

        repeat (3) @(negedge clk_bus);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mem_copy", mem_copy, 1'b0);
        check("rst_we", mem_copy_we, 1'b0);
        check("rst_rd", mem_copy_rd, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_addr", mem_copy_addr, 25'h0);
        check("rst_wdata", mem_copy_data_i, 16'h0);
        reset_n = 1'b1;
        @(posedge clk_bus); #1;

        load_bytes = '{8'h34, 8'h12, 8'h78, 8'h56};
        run_load(25'hFD000, 4, 1'b0, 1'b0);

        load_bytes = '{8'hAA, 8'hBB, 8'hCC};
        run_load(25'hE0001, 3, 1'b1, 1'b1);

        mem_seed = 16'hBEEF;
        run_save(25'h0, 2, 1'b0, 1);

        // Zero length
        w0 = we_rises; r0 = rd_rises;
        exp_virt = 1'b1;
        issue(1'b0, 1'b1, 25'h123, 0);
        @(negedge clk_bus);
        check("zl_busy", busy, 1'b1);
        check("zl_virt", mem_copy_virt, 1'b1);
        check("zl_done_early", done, 1'b0);
        @(negedge clk_bus);
        check("zl_busy_end", busy, 1'b0);
        check("zl_done", done, 1'b1);
        check("zl_virt_end", mem_copy_virt, 1'b0);
        exp_dones++;
        check("zl_no_we", we_rises - w0, 0);
        check("zl_no_rd", rd_rises - r0, 0);
        @(posedge clk_bus); #1;

        // Abort during the second high cycle of the first write
        load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        w.addr = 25'h40000; w.data = 16'h2211;
        exp_wr.push_back(w);
        exp_virt = 1'b0;
        w0 = we_rises;
        issue(1'b0, 1'b0, 25'h40000, 8);
        feed(2);
        g = 0;
        do begin @(negedge clk_bus); g++; end while (!mem_copy_we && g < 50);
        check("abort_we_seen", mem_copy_we, 1'b1);
        ign_we_len = 1;
        @(posedge clk_bus); #1;
        cmd_abort = 1'b1;
        @(posedge clk_bus); #1;
        cmd_abort = 1'b0;
        @(negedge clk_bus);
        check("abort_we_low", mem_copy_we, 1'b0);
        check("abort_done_not_yet", done, 1'b0);
        @(negedge clk_bus);
        check("abort_done", done, 1'b1);
        check("abort_mem_copy", mem_copy, 1'b0);
        exp_dones++;
        ign_we_len = 0;
        check("abort_one_write", we_rises - w0, 1);
        @(posedge clk_bus); #1;
        load_bytes = '{8'h9A, 8'hBC};
        run_load(25'h50002, 2, 1'b0, 1'b0);

        // Address wraps modulo 2^25
        load_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(25'h1FFFFFE, 4, 1'b1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            len  = $urandom_range(1, 9);
            base = 25'($urandom);
            virt = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                load_bytes.delete();
                for (int i = 0; i < len; i++) load_bytes.push_back(8'($urandom));
                run_load(base, len, virt, 1'b0);
            end else begin
                mem_seed = 16'($urandom);
                run_save(base, len, virt, 2);
            end
        end

        // Asynchronous reset while a read pulse is active
        issue(1'b1, 1'b1, 25'h100, 4);
        g = 0;
        do begin @(negedge clk_bus); g++; end while (!mem_copy_rd && g < 50);
        check("rst_rd_seen", mem_copy_rd, 1'b1);
        ign_rd_len = 1;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_mem_copy", mem_copy, 1'b0);
        check("arst_rd", mem_copy_rd, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_virt", mem_copy_virt, 1'b0);
        repeat (3) @(negedge clk_bus);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_bus);
            check("post_rst_idle", busy, 1'b0);
            check("post_rst_no_done", done, 1'b0);
        end
        ign_rd_len = 0;
        @(posedge clk_bus); #1;
        load_bytes = '{8'hDE, 8'hAD};
        run_load(25'h60000, 2, 1'b0, 1'b0);

        repeat (5) @(negedge clk_bus);
        check("done_count", done_seen, exp_dones);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Initiator side of the memory block's mem_copy port.
- Streams bytes from the OSD/loader channel into SDRAM, or from SDRAM back out to it, as 16-bit word accesses. Used for ROM image loading, snapshot load and snapshot save.
- Produces clean registered mem_copy_we/mem_copy_rd pulses. The memory block samples ROM availability and start addresses on the rising edge of mem_copy_we.

Parameters:
- WE_CYCLES, 4: clk_bus cycles mem_copy_we is held high per word (covers the SDRAM clock-domain write latency).
- RD_CYCLES, 6: clk_bus cycles mem_copy_rd is held high before mem_copy_data_o is sampled.
- GAP_CYCLES, 1: minimum low cycles between consecutive we/rd pulses; legal range 1 or more.

Ports:
- clk_bus  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle command strobe; ignored while busy.
- cmd_save  in  1  0 = load (stream to memory), 1 = save (memory to stream).
- cmd_virt  in  1  copy through the CPU virtual map instead of physical addresses.
- cmd_base  in  25  start byte address; bit 0 forced to 0.
- cmd_len  in  17  transfer length in bytes, 0..65536.
- cmd_abort  in  1  terminate the transfer.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at normal completion or abort.
- in_valid / in_data[7:0] / in_ready  in/in/out  load byte stream, valid/ready handshake.
- out_valid / out_data[7:0] / out_ready  out/out/in  save byte stream, valid/ready handshake.
- mem_copy  out  1  owns memory port.
- mem_copy_virt  out  1  latched copy of cmd_virt.
- mem_copy_addr  out  25  word byte-address.
- mem_copy_data_i  out  16  write data.
- mem_copy_data_o  in  16  read data.
- mem_copy_we  out  1  write pulse.
- mem_copy_rd  out  1  read pulse.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- All outputs are registered; none is combinational from inputs.
- cmd_start in IDLE:
  - Latch base (bit0 = 0), len, save and virt.
  - Assert busy and mem_copy the next cycle.
  - mem_copy_virt is stable for the whole command.
- len = 0: go straight to DONE with no memory access. busy lasts 1 cycle and done pulses.
- Byte order is little-endian: the even byte is the low byte [7:0], the odd byte the high byte [15:8].
- States: IDLE, LD_LO, LD_HI, WR, GAP, RD, TX_LO, TX_HI, DONE.
- Load path:
  - LD_LO: in_ready = 1. On in_valid & in_ready, capture the low byte.
    - If this is the last byte (odd len), the high byte = 8'h00; go to WR.
    - Otherwise go to LD_HI.
  - LD_HI: capture the high byte, then go to WR.
  - WR: mem_copy_data_i and mem_copy_addr stay stable one cycle before and throughout the pulse. mem_copy_we is high exactly WE_CYCLES cycles.
  - GAP: we and rd low for GAP_CYCLES. Then add 2 to the address and 2 to the byte count (saturating at len). Go to LD_LO if bytes remain, else DONE.
- Save path:
  - RD: mem_copy_rd is high RD_CYCLES cycles. mem_copy_data_o is captured on the last rd-high cycle.
  - TX_LO: present the low byte; out_valid = 1.
  - TX_HI: present the high byte, skipped if it lies beyond len.
  - Each byte advances on out_valid & out_ready. out_data is held stable while out_valid & !out_ready.
  - Then GAP, then RD or DONE.
- Byte count: 17-bit. 65536 bytes = 32768 words. Address wraps modulo 2^25 without a flag.
- DONE: done = 1 for one cycle. mem_copy, busy, in_ready and out_valid drop in the same cycle. Return to IDLE.
- cmd_abort while busy:
  - we/rd deassert next cycle, even mid-pulse (a partial write is acceptable).
  - Any pending half word is discarded. Go to DONE.
  - Abort in IDLE is ignored.
- Abort and a stream handshake in the same cycle: abort wins and the byte is consumed but not written.
- cmd_start while busy is ignored. cmd_start and cmd_abort together in IDLE: start wins.
- Asynchronous reset mid-transfer: every output drops to 0 immediately. No done pulse.
- Pulse rule: mem_copy_we never stays high across two words. Each word gives exactly one rising edge.

Decomposition:
- Shared package bk_mem_pkg holds:
  - state enum for this block;
  - ROM map constants (ROM_P10, A16M_ROM, SMK512_ROM, BIOS11, etc.) for loader address generation;
  - START_ADDR_OFFS = 25'hFCE.
- One sub-module: mem_pulse_timer. It loads a count, holds an output high N cycles, then low M cycles, and raises a finish strobe. It is instantiated once and shared between the we and rd paths.

Test Plan:
- Load: base 25'hFD000, len 4, bytes 34,12,78,56 -> exactly two writes, 16'h1234 @ 25'hFD000 and 16'h5678 @ 25'hFD002. Each we is high 4 cycles, separated by at least 1 low cycle. Then one done pulse.
- Odd load: base 25'hE0001, len 3, bytes AA,BB,CC -> writes 16'hBBAA @ 25'hE0000 and 16'h00CC @ 25'hE0002. in_ready stays low after the 3rd byte.
- Save with backpressure: memory returns 16'hBEEF @ 25'h0, len 2, out_ready toggling 1/0 -> out_data EF then BE, each held stable while stalled. Exactly one rd pulse of 6 cycles.
- Zero length and virt: cmd_len 0, cmd_virt 1 -> busy for 1 cycle, done, no we/rd edge. mem_copy_virt is 1 only during busy.
- Abort during WR cycle 2 -> we low next cycle, done 1 cycle later, mem_copy 0. A new command afterwards starts at its own base.
- reset_n low during RD -> mem_copy, mem_copy_rd, busy and out_valid are 0 immediately. After release the block sits in IDLE with no done.
